// File: rtl/power_stim_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : power_stim_sequencer
// Purpose  : Plaintext / trigger sequencer for side-channel trace capture.
//            Produces per-slot plaintext (LFSR, fixed, or TVLA interleave),
//            a load pulse, a scope trigger window, and captures the result.
// Revision : 1.0  initial release
// ============================================================================
module power_stim_sequencer #(
  parameter int              DATA_W     = 128,
  parameter logic [DATA_W-1:0] LFSR_SEED  = 128'hACE1ACE159C359C3B386B386670D670C,
  parameter logic [DATA_W-1:0] LFSR_TAPS  = (128'd1 << 127) | (128'd1 << 109) |
                                            (128'd1 << 85)  | 128'd1,
  parameter logic [DATA_W-1:0] FIXED_TEXT = '0,
  parameter int              PERIOD     = 256,
  parameter int              START_AT   = 240
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable_i,
  input  logic [1:0]        mode_i,
  input  logic              busy_i,
  input  logic [DATA_W-1:0] result_i,
  output logic              start_o,
  output logic [DATA_W-1:0] text_o,
  output logic              class_o,
  output logic              trigger_o,
  output logic [DATA_W-1:0] result_o,
  output logic              result_valid_o,
  output logic [15:0]       trace_cnt_o,
  output logic [7:0]        overrun_cnt_o
);

  localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  // Last slot cycle, and the cycle whose closing edge performs the text update
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_UPD  = CNT_W'(START_AT - 1);
  localparam logic [15:0]      CLS_TAPS = 16'hB400;
  localparam logic [15:0]      CLS_SEED = 16'hACE1;
  localparam logic [1:0]       MODE_FIXED = 2'd1;
  localparam logic [1:0]       MODE_TVLA  = 2'd2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        mode_q;
  logic [DATA_W-1:0] lfsr;
  logic [15:0]       cls_lfsr;
  logic              pending;
  logic              seen;

  logic [DATA_W-1:0] lfsr_step;
  logic [15:0]       cls_step;
  logic              draw;
  logic              in_run;
  logic              at_upd;
  logic              issue;
  logic              take_random;

  assign lfsr_step = {lfsr[DATA_W-2:0], ^(lfsr & LFSR_TAPS)};
  assign draw      = ^(cls_lfsr & CLS_TAPS);
  assign cls_step  = {cls_lfsr[14:0], draw};
  assign in_run    = (state == RUN);
  assign at_upd    = in_run && (cnt == CNT_UPD);
  // start_o is registered, so busy is judged in the cycle before the start slot
  assign issue     = at_upd && !busy_i;
  assign take_random = (mode_q == MODE_TVLA)  ? draw :
                       (mode_q == MODE_FIXED) ? 1'b0 : 1'b1;

  // Slot FSM: idle/run control, slot counter and mode latching
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      mode_q <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (enable_i) begin
            mode_q <= mode_i;
            state  <= RUN;
          end
        end
        RUN: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (!enable_i) begin
              state <= IDLE;
            end else begin
              mode_q <= mode_i;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Plaintext generation; the main LFSR only advances for random-class slots
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr     <= LFSR_SEED;
      text_o   <= LFSR_SEED;
      cls_lfsr <= CLS_SEED;
      class_o  <= 1'b1;
    end else if (at_upd) begin
      if (mode_q == MODE_TVLA) begin
        cls_lfsr <= cls_step;
      end
      if (take_random) begin
        lfsr    <= lfsr_step;
        text_o  <= lfsr_step;
        class_o <= 1'b1;
      end else begin
        text_o  <= FIXED_TEXT;
        class_o <= 1'b0;
      end
    end
  end

  // Load pulse, trigger window and trace/overrun statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      start_o       <= 1'b0;
      trigger_o     <= 1'b0;
      trace_cnt_o   <= '0;
      overrun_cnt_o <= '0;
    end else begin
      start_o   <= issue;
      trigger_o <= in_run && (cnt != CNT_LAST) && (cnt >= CNT_UPD);
      if (issue) begin
        trace_cnt_o <= trace_cnt_o + 16'd1;
      end
      if (at_upd && busy_i && (overrun_cnt_o != 8'hFF)) begin
        overrun_cnt_o <= overrun_cnt_o + 8'd1;
      end
    end
  end

  // Result capture: wait for the core to go busy, then take result when it drops
  always_ff @(posedge clk) begin
    if (rst) begin
      pending        <= 1'b0;
      seen           <= 1'b0;
      result_o       <= '0;
      result_valid_o <= 1'b0;
    end else begin
      result_valid_o <= 1'b0;
      if (issue) begin
        pending <= 1'b1;
        seen    <= 1'b0;
      end else if (pending) begin
        if (busy_i) begin
          seen <= 1'b1;
        end else if (seen) begin
          result_o       <= result_i;
          result_valid_o <= 1'b1;
          pending        <= 1'b0;
          seen           <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_power_stim_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_power_stim_sequencer
// Purpose  : Directed bench for power_stim_sequencer with a text/result
//            scoreboard and a small plaintext reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_power_stim_sequencer;

  localparam int PER = 16;
  localparam int ST  = 12;
  localparam logic [127:0] SEED  = 128'hACE1ACE159C359C3B386B386670D670C;
  localparam logic [127:0] TAPS  = (128'd1 << 127) | (128'd1 << 109) |
                                   (128'd1 << 85)  | 128'd1;
  localparam logic [127:0] FIXED = 128'h0;

  logic         clk;
  logic         rst;
  logic         enable_i;
  logic [1:0]   mode_i;
  logic         busy_i;
  logic [127:0] result_i;
  logic         start_o;
  logic [127:0] text_o;
  logic         class_o;
  logic         trigger_o;
  logic [127:0] result_o;
  logic         result_valid_o;
  logic [15:0]  trace_cnt_o;
  logic [7:0]   overrun_cnt_o;

  typedef struct packed {
    logic [127:0] text;
    logic         cls;
  } exp_t;

  exp_t         sb_q[$];
  logic [127:0] res_q[$];

  int           n_vec;
  int           n_err;
  logic [127:0] m_main;
  logic [15:0]  m_cls;
  int           trace_exp;
  int           ovr_exp;
  int           cap_cnt;
  bit           cap_en;
  bit           force_busy;
  bit           valid_due;
  logic [127:0] res_val;

  power_stim_sequencer #(
    .DATA_W  (128),
    .PERIOD  (PER),
    .START_AT(ST)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable_i      (enable_i),
    .mode_i        (mode_i),
    .busy_i        (busy_i),
    .result_i      (result_i),
    .start_o       (start_o),
    .text_o        (text_o),
    .class_o       (class_o),
    .trigger_o     (trigger_o),
    .result_o      (result_o),
    .result_valid_o(result_valid_o),
    .trace_cnt_o   (trace_cnt_o),
    .overrun_cnt_o (overrun_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] main_step(input logic [127:0] x);
    return {x[126:0], ^(x & TAPS)};
  endfunction

  function automatic logic [15:0] cls_next(input logic [15:0] x);
    return {x[14:0], ^(x & 16'hB400)};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the edge and the
  // scoreboards are drained whenever the DUT presents a start or a result.
  task automatic tick();
    exp_t         e;
    logic [127:0] r;
    @(posedge clk);
    #1;
    if (start_o) begin
      if (sb_q.size() == 0) begin
        check("unexpected_start", 128'(start_o), 128'd0);
      end else begin
        e = sb_q.pop_front();
        check("sb_text", text_o, e.text);
        check("sb_class", 128'(class_o), 128'(e.cls));
      end
    end
    if (result_valid_o) begin
      if (res_q.size() == 0) begin
        check("unexpected_result", 128'(result_valid_o), 128'd0);
      end else begin
        r = res_q.pop_front();
        check("sb_result", result_o, r);
      end
    end
  endtask

  // One full trace slot; drop_at >= 0 switches to mode 1 and drops enable there.
  task automatic run_slot(input int drop_at);
    logic [1:0]   cur_mode;
    bit           exp_start;
    bit           take_rand;
    logic [127:0] exp_text;
    logic         exp_cls;
    cur_mode  = mode_i;
    exp_start = 1'b0;
    exp_text  = '0;
    exp_cls   = 1'b1;
    for (int p = 0; p < PER; p++) begin
      tick();
      check("start_o", 128'(start_o), 128'(p == ST && exp_start));
      check("trigger_o", 128'(trigger_o), 128'(p >= ST));
      check("result_valid_o", 128'(result_valid_o), 128'(valid_due));
      valid_due = 1'b0;
      if (p == ST && !exp_start) begin
        check("text_no_start", text_o, exp_text);
        check("class_no_start", 128'(class_o), 128'(exp_cls));
      end
      if (p == drop_at) begin
        mode_i   = 2'd1;
        enable_i = 1'b0;
      end
      if (force_busy) begin
        busy_i = 1'b1;
      end else if (cap_cnt > 1) begin
        busy_i = 1'b1;
        cap_cnt--;
      end else if (cap_cnt == 1) begin
        busy_i   = 1'b0;
        res_val  = res_val + 128'h0000_0001_0000_0000_0000_0000_0000_0011;
        result_i = res_val;
        res_q.push_back(res_val);
        cap_cnt   = 0;
        valid_due = 1'b1;
      end else begin
        busy_i = 1'b0;
      end
      if (p == ST - 1) begin
        case (cur_mode)
          2'd1:    take_rand = 1'b0;
          2'd2: begin
            m_cls     = cls_next(m_cls);
            take_rand = m_cls[0];
          end
          default: take_rand = 1'b1;
        endcase
        if (take_rand) begin
          m_main   = main_step(m_main);
          exp_text = m_main;
          exp_cls  = 1'b1;
        end else begin
          exp_text = FIXED;
          exp_cls  = 1'b0;
        end
        exp_start = !busy_i;
        if (exp_start) begin
          sb_q.push_back('{text: exp_text, cls: exp_cls});
          trace_exp++;
        end else if (ovr_exp < 255) begin
          ovr_exp++;
        end
      end
      if (p == ST && exp_start && cap_en) begin
        cap_cnt = 5;
      end
    end
  endtask

  initial begin
    int trace_before;
    n_vec      = 0;
    n_err      = 0;
    m_main     = SEED;
    m_cls      = 16'hACE1;
    trace_exp  = 0;
    ovr_exp    = 0;
    cap_cnt    = 0;
    cap_en     = 1'b0;
    force_busy = 1'b0;
    valid_due  = 1'b0;
    res_val    = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;

    // Reset
    rst      = 1'b1;
    enable_i = 1'b0;
    mode_i   = 2'd0;
    busy_i   = 1'b0;
    result_i = '0;
    tick();
    tick();
    check("rst_start", 128'(start_o), 128'd0);
    check("rst_trigger", 128'(trigger_o), 128'd0);
    check("rst_valid", 128'(result_valid_o), 128'd0);
    check("rst_text", text_o, SEED);
    check("rst_class", 128'(class_o), 128'd1);
    check("rst_result", result_o, 128'd0);
    check("rst_trace", 128'(trace_cnt_o), 128'd0);
    check("rst_overrun", 128'(overrun_cnt_o), 128'd0);

    // Random mode, idle core
    rst      = 1'b0;
    enable_i = 1'b1;
    mode_i   = 2'd0;
    repeat (10) run_slot(-1);
    check("trace_after_random", 128'(trace_cnt_o), 128'd10);
    check("overrun_after_random", 128'(overrun_cnt_o), 128'd0);

    // Capture: core busy for 4 cycles after each start
    cap_en = 1'b1;
    repeat (5) run_slot(-1);
    cap_en = 1'b0;

    // TVLA interleave
    mode_i = 2'd2;
    repeat (1000) run_slot(-1);
    check("trace_after_tvla", 128'(trace_cnt_o), 128'(trace_exp));
    check("results_drained", 128'(res_q.size()), 128'd0);

    // Overrun: core permanently busy
    mode_i       = 2'd0;
    force_busy   = 1'b1;
    trace_before = trace_exp;
    repeat (300) run_slot(-1);
    check("overrun_sat", 128'(overrun_cnt_o), 128'd255);
    check("overrun_model", 128'(overrun_cnt_o), 128'(ovr_exp));
    check("trace_held", 128'(trace_cnt_o), 128'(trace_before));

    // The last TVLA start is still pending and has seen busy; releasing
    // busy must capture the current result.
    force_busy = 1'b0;
    cap_cnt    = 1;

    // Mid-slot mode change and enable drop
    run_slot(5);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_start", 128'(start_o), 128'd0);
      check("idle_trigger", 128'(trigger_o), 128'd0);
      check("idle_valid", 128'(result_valid_o), 128'd0);
    end
    enable_i = 1'b1;
    run_slot(-1);
    run_slot(-1);
    check("trace_final", 128'(trace_cnt_o), 128'(trace_exp));
    check("class_fixed_final", 128'(class_o), 128'd0);
    check("text_fixed_final", text_o, FIXED);
    check("sb_drained", 128'(sb_q.size()), 128'd0);
    check("res_drained", 128'(res_q.size()), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
